// File: rtl/clock_divider_arbiter.sv
// clock_divider_arbiter - round-robin owner selection for a shared clock divider's divisor input,
// with a shadow period counter that produces the per-period tick and enforces a minimum hold.
module clock_divider_arbiter #(
   parameter int N            = 3,
   parameter int HOLD_PERIODS = 2,
   parameter int DEF_DIV      = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*28-1:0] req_divisor,
   output logic [N-1:0]    grant,
   output logic [27:0]     divisor,
   output logic            tick,
   output logic            busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int HW = $clog2(HOLD_PERIODS + 1);

   typedef enum logic [1:0] {IDLE, RUN, GUARD} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [N-1:0]  r_grant;
   logic [N-1:0]  w_win_oh;
   logic [27:0]   r_divisor;
   logic [27:0]   r_cnt;
   logic [27:0]   w_win_div;
   logic [27:0]   w_win_clamped;
   logic [HW-1:0] r_periods;
   logic [PW-1:0] r_rr_ptr;
   logic [PW-1:0] w_winner;
   logic          w_found;
   logic          w_tick;
   logic          w_other;
   logic          w_owner_req;
   logic          w_hold_met;
   logic          w_load;

   function automatic int rr_idx(input int ptr, input int k);
      return (ptr + k) % N;
   endfunction

   // Search begins just after the last winner, so a released owner ends up last in line.
   always_comb begin
      w_found   = 1'b0;
      w_winner  = '0;
      w_win_oh  = '0;
      w_win_div = '0;
      for (int k = 1; k <= N; k++) begin
         if (!w_found && req[rr_idx(int'(r_rr_ptr), k)]) begin
            w_found                               = 1'b1;
            w_winner                              = PW'(rr_idx(int'(r_rr_ptr), k));
            w_win_oh[rr_idx(int'(r_rr_ptr), k)]   = 1'b1;
            w_win_div = req_divisor[28*rr_idx(int'(r_rr_ptr), k) +: 28];
         end
      end
      w_win_clamped = (w_win_div < 28'd2) ? 28'd2 : w_win_div;
   end

   assign w_tick      = (r_state == RUN) && (r_cnt == r_divisor - 28'd1);
   assign w_other     = |(req & ~r_grant);
   assign w_owner_req = |(req & r_grant);
   assign w_hold_met  = (int'(r_periods) + 1 >= HOLD_PERIODS);

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE, GUARD: begin
            if (w_found) begin
               w_state_nxt = RUN;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (w_tick && (!w_owner_req || (w_hold_met && w_other)))
               w_state_nxt = GUARD;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_divisor <= 28'(DEF_DIV);
         r_cnt     <= '0;
         r_periods <= '0;
         r_rr_ptr  <= PW'(N - 1);
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_grant   <= w_win_oh;
            r_divisor <= w_win_clamped;
            r_cnt     <= '0;
            r_periods <= '0;
            r_rr_ptr  <= w_winner;
         end else if (r_state == RUN) begin
            if (w_tick) begin
               r_cnt <= '0;
               if (int'(r_periods) < HOLD_PERIODS)
                  r_periods <= r_periods + HW'(1);
               if (w_state_nxt == GUARD)
                  r_grant <= '0;
            end else begin
               r_cnt <= r_cnt + 28'd1;
            end
         end
      end
   end

   assign grant   = r_grant;
   assign divisor = r_divisor;
   assign tick    = w_tick;
   assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_clock_divider_arbiter.sv
// tb_clock_divider_arbiter - directed and randomized checks against a period-level reference model.
module tb_clock_divider_arbiter;

   localparam int N    = 3;
   localparam int HOLD = 2;
   localparam int DEF  = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N*28-1:0] req_divisor = '0;
   logic [N-1:0]    grant;
   logic [27:0]     divisor;
   logic            tick;
   logic            busy;

   int checks = 0;
   int errors = 0;

   // reference model: mode 0 idle, 1 owning, 2 gap cycle
   int m_mode, m_owner, m_div, m_pos, m_per, m_rr;

   clock_divider_arbiter #(.N(N), .HOLD_PERIODS(HOLD), .DEF_DIV(DEF)) dut (
      .clk(clk), .rst(rst), .req(req), .req_divisor(req_divisor),
      .grant(grant), .divisor(divisor), .tick(tick), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL timeout %s observed no event expected event within budget", tag);
   endtask

   function automatic int div_of(input int i);
      logic [N*28-1:0] sh;
      sh = req_divisor >> (28 * i);
      return int'(sh[27:0]);
   endfunction

   task automatic m_reset();
      m_mode = 0; m_owner = 0; m_div = DEF; m_pos = 0; m_per = 0; m_rr = N - 1;
   endtask

   task automatic m_step();
      int  w;
      bit  leave;
      if (m_mode == 1) begin
         if (m_pos == m_div - 1) begin
            leave = !req[m_owner] ||
                    ((m_per + 1 >= HOLD) && ((req & ~(N'(1) << m_owner)) != 0));
            m_pos = 0;
            if (m_per < HOLD) m_per++;
            if (leave) m_mode = 2;
         end else begin
            m_pos++;
         end
      end else begin
         w = -1;
         for (int k = 1; k <= N; k++)
            if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
         if (w >= 0) begin
            m_mode = 1; m_owner = w; m_rr = w; m_pos = 0; m_per = 0;
            m_div = (div_of(w) < 2) ? 2 : div_of(w);
         end else begin
            m_mode = 0;
         end
      end
   endtask

   task automatic check_model();
      chk("grant", 32'(grant), (m_mode == 1) ? (32'd1 << m_owner) : 32'd0);
      chk("divisor", 32'(divisor), 32'(m_div));
      chk("tick", 32'(tick), 32'((m_mode == 1) && (m_pos == m_div - 1)));
      chk("busy", 32'(busy), 32'(m_mode != 0));
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst) m_reset(); else m_step();
      #1;
      check_model();
   endtask

   task automatic to_idle();
      int n;
      req = '0;
      n = 0;
      do begin cyc(); n++; end while (m_mode != 0 && n < 60);
      if (m_mode != 0) timeout("to_idle");
   endtask

   task automatic set_div(input int i, input int d);
      req_divisor[28*i +: 28] = 28'(d);
   endtask

   initial begin
      int n;
      m_reset();
      // reset held with requests pending
      req = 3'b101;
      repeat (3) cyc();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_div", 32'(divisor), 32'd4);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      req = '0;
      rst = 1'b0;
      repeat (4) cyc();
      chk("idle_busy", 32'(busy), 32'd0);

      // lone requester, divisor 4
      set_div(0, 4);
      req = 3'b001;
      cyc();
      chk("lone_grant", 32'(grant), 32'b001);
      repeat (40) cyc();
      chk("lone_no_guard", 32'(grant), 32'b001);
      to_idle();

      // three-way rotation 4/6/8
      set_div(1, 6); set_div(2, 8);
      req = 3'b111;
      repeat (60) cyc();
      to_idle();

      // clamp of 0 then 1
      set_div(1, 0);
      req = 3'b010;
      cyc();
      chk("clamp0", 32'(divisor), 32'd2);
      repeat (6) cyc();
      to_idle();
      set_div(1, 1);
      req = 3'b010;
      cyc();
      chk("clamp1", 32'(divisor), 32'd2);
      repeat (6) cyc();
      to_idle();

      // mid-period drop by a div-6 owner
      set_div(0, 6);
      req = 3'b001;
      n = 0;
      do begin cyc(); n++; end while (!(m_mode == 1 && m_pos == 1) && n < 20);
      if (!(m_mode == 1 && m_pos == 1)) timeout("drop_pos");
      req = '0;
      repeat (4) cyc();
      chk("drop_held", 32'(grant), 32'b001);
      to_idle();
      chk("drop_div", 32'(divisor), 32'd6);

      // asynchronous reset in the middle of a div-8 period
      set_div(2, 8);
      req = 3'b100;
      n = 0;
      do begin cyc(); n++; end while (!(m_mode == 1 && m_pos == 3) && n < 20);
      if (!(m_mode == 1 && m_pos == 3)) timeout("async_pos");
      #2 rst = 1'b1;
      #1;
      m_reset();
      chk("async_grant", 32'(grant), 32'd0);
      chk("async_div", 32'(divisor), 32'd4);
      chk("async_busy", 32'(busy), 32'd0);
      repeat (2) cyc();
      rst = 1'b0;
      cyc();
      chk("after_rst", 32'(grant), 32'b100);
      to_idle();
      req = 3'b011;
      cyc();
      chk("rr_restart", 32'(grant), 32'b001);
      to_idle();

      // randomized traffic, divisors re-drawn freely (only sampled at grant)
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, (1 << N) - 1));
         if ($urandom_range(0, 3) == 0) set_div($urandom_range(0, N - 1), $urandom_range(0, 9));
         if (i == 300) rst = 1'b1;
         if (i == 302) rst = 1'b0;
         cyc();
      end
      to_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
